// File: rtl/minefield_board.sv
// Cell-state memory for the Minesweeper core: mine/revealed/flag/count per cell behind a valid/ready command port.
// Optional TORUS_WRAP_EN makes neighbour coordinates wrap around the board edges.
module minefield_board #(
    parameter int WIDTH   = 8,
    parameter int HEIGHT  = 8,
    parameter int COUNT_W = 4,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT),
    localparam int NW = $clog2(WIDTH*HEIGHT+1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [XW-1:0]      cmd_x,
    input  logic [YW-1:0]      cmd_y,
    output logic               done,
    output logic               result,
    output logic               err,
    input  logic [XW-1:0]      rd_x,
    input  logic [YW-1:0]      rd_y,
    output logic               rd_mine,
    output logic               rd_revealed,
    output logic               rd_flag,
    output logic [COUNT_W-1:0] rd_count,
    output logic [NW-1:0]      mine_total,
    output logic [NW-1:0]      revealed_total
);
    localparam int CELLS = WIDTH*HEIGHT;
    localparam int IW    = $clog2(CELLS);
    localparam int XS    = XW+2;
    localparam int YS    = YW+2;
    localparam logic [1:0] OP_CLEAR = 2'd0, OP_PLACE = 2'd1, OP_REVEAL = 2'd2, OP_FLAG = 2'd3;

    typedef enum logic [2:0] {IDLE, CLR, MARK, NBR, CELL, DONE} state_t;
    state_t state, state_next;

    logic               mine     [CELLS];
    logic               revealed [CELLS];
    logic               flag     [CELLS];
    logic [COUNT_W-1:0] count    [CELLS];

    logic [1:0]    cur_op;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic [IW-1:0] clr_idx;
    logic [2:0]    nbr_k;
    logic          res_flag, err_flag;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
        return (&c) ? c : c + COUNT_W'(1);
    endfunction

    function automatic logic [IW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return IW'(y) * IW'(WIDTH) + IW'(x);
    endfunction

    // Neighbour order N, NE, E, SE, S, SW, W, NW; north is dy=-1, east is dx=+1.
    function automatic logic signed [1:0] off_dx(input logic [2:0] k);
        case (k)
            3'd1, 3'd2, 3'd3: return 2'sd1;
            3'd5, 3'd6, 3'd7: return -2'sd1;
            default:          return 2'sd0;
        endcase
    endfunction

    function automatic logic signed [1:0] off_dy(input logic [2:0] k);
        case (k)
            3'd0, 3'd1, 3'd7: return -2'sd1;
            3'd3, 3'd4, 3'd5: return 2'sd1;
            default:          return 2'sd0;
        endcase
    endfunction

    logic signed [1:0]    dx, dy;
    logic signed [XS-1:0] nx_s;
    logic signed [YS-1:0] ny_s;
    logic                 x_lo, x_hi, y_lo, y_hi, nbr_ok;
    logic [XW-1:0]        nx;
    logic [YW-1:0]        ny;
    logic [IW-1:0]        nidx, tidx, ridx;
    logic                 cmd_in_range, rd_in_range;

    always_comb begin
        dx   = off_dx(nbr_k);
        dy   = off_dy(nbr_k);
        nx_s = $signed({2'b00, cur_x}) + $signed({{XW{dx[1]}}, dx});
        ny_s = $signed({2'b00, cur_y}) + $signed({{YW{dy[1]}}, dy});
        x_lo = nx_s[XS-1];
        y_lo = ny_s[YS-1];
        x_hi = nx_s >= $signed(XS'(WIDTH));
        y_hi = ny_s >= $signed(YS'(HEIGHT));
`ifdef TORUS_WRAP_EN
        nx     = x_lo ? XW'(WIDTH-1)  : (x_hi ? '0 : nx_s[XW-1:0]);
        ny     = y_lo ? YW'(HEIGHT-1) : (y_hi ? '0 : ny_s[YW-1:0]);
        nbr_ok = 1'b1;
`else
        nx     = nx_s[XW-1:0];
        ny     = ny_s[YW-1:0];
        nbr_ok = !x_lo && !x_hi && !y_lo && !y_hi;
`endif
    end

    assign nidx         = cell_idx(nx, ny);
    assign tidx         = cell_idx(cur_x, cur_y);
    assign ridx         = cell_idx(rd_x, rd_y);
    assign cmd_in_range = ({1'b0, cmd_x} < (XW+1)'(WIDTH)) && ({1'b0, cmd_y} < (YW+1)'(HEIGHT));
    assign rd_in_range  = ({1'b0, rd_x} < (XW+1)'(WIDTH)) && ({1'b0, rd_y} < (YW+1)'(HEIGHT));

    always_comb begin
        rd_mine     = 1'b0;
        rd_revealed = 1'b0;
        rd_flag     = 1'b0;
        rd_count    = '0;
        if (rd_in_range) begin
            rd_mine     = mine[ridx];
            rd_revealed = revealed[ridx];
            rd_flag     = flag[ridx];
            rd_count    = count[ridx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_op == OP_CLEAR)  state_next = CLR;
                    else if (!cmd_in_range)  state_next = DONE;
                    else if (cmd_op == OP_PLACE) state_next = MARK;
                    else                     state_next = CELL;
                end
            end
            CLR:  if (clr_idx == IW'(CELLS-1)) state_next = DONE;
            MARK: state_next = mine[tidx] ? DONE : NBR;
            NBR:  if (nbr_k == 3'd7) state_next = DONE;
            CELL: state_next = DONE;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign result = done && res_flag;
    assign err    = done && err_flag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CELLS; i++) begin
                mine[i]     <= 1'b0;
                revealed[i] <= 1'b0;
                flag[i]     <= 1'b0;
                count[i]    <= '0;
            end
            mine_total     <= '0;
            revealed_total <= '0;
            cur_op         <= OP_CLEAR;
            cur_x          <= '0;
            cur_y          <= '0;
            clr_idx        <= '0;
            nbr_k          <= '0;
            res_flag       <= 1'b0;
            err_flag       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    cur_op   <= cmd_op;
                    cur_x    <= cmd_x;
                    cur_y    <= cmd_y;
                    clr_idx  <= '0;
                    nbr_k    <= '0;
                    res_flag <= 1'b0;
                    err_flag <= (cmd_op != OP_CLEAR) && !cmd_in_range;
                    if (cmd_op == OP_CLEAR) begin
                        mine_total     <= '0;
                        revealed_total <= '0;
                    end
                end
                CLR: begin
                    mine[clr_idx]     <= 1'b0;
                    revealed[clr_idx] <= 1'b0;
                    flag[clr_idx]     <= 1'b0;
                    count[clr_idx]    <= '0;
                    clr_idx           <= clr_idx + IW'(1);
                end
                MARK: begin
                    if (mine[tidx]) res_flag <= 1'b1;
                    else begin
                        mine[tidx] <= 1'b1;
                        mine_total <= mine_total + NW'(1);
                    end
                end
                NBR: begin
                    if (nbr_ok) count[nidx] <= sat_inc(count[nidx]);
                    nbr_k <= nbr_k + 3'd1;
                end
                CELL: begin
                    if (cur_op == OP_REVEAL) begin
                        if (flag[tidx]) err_flag <= 1'b1;
                        else begin
                            res_flag <= mine[tidx];
                            if (!revealed[tidx]) begin
                                revealed[tidx] <= 1'b1;
                                revealed_total <= revealed_total + NW'(1);
                            end
                        end
                    end else if (cur_op == OP_FLAG && !revealed[tidx]) begin
                        flag[tidx] <= !flag[tidx];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_minefield_board.sv
// Directed bench for minefield_board on an 8x8 board with a 3-bit neighbour count.
// Expectations follow TORUS_WRAP_EN when the macro is defined for the build.
module tb_minefield_board;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [2:0]    cmd_x = 3'd0;
    logic [2:0]    cmd_y = 3'd0;
    logic          done, result, err;
    logic [2:0]    rd_x = 3'd0;
    logic [2:0]    rd_y = 3'd0;
    logic          rd_mine, rd_revealed, rd_flag;
    logic [CW-1:0] rd_count;
    logic [6:0]    mine_total, revealed_total;

    minefield_board #(.WIDTH(W), .HEIGHT(H), .COUNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y),
        .done(done), .result(result), .err(err),
        .rd_x(rd_x), .rd_y(rd_y),
        .rd_mine(rd_mine), .rd_revealed(rd_revealed), .rd_flag(rd_flag), .rd_count(rd_count),
        .mine_total(mine_total), .revealed_total(revealed_total)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic          em [64];
    logic          er [64];
    logic          ef [64];
    logic [CW-1:0] ec [64];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic int ci(input int x, input int y);
        return y*W + x;
    endfunction

    task automatic clr_exp();
        for (int i = 0; i < 64; i++) begin
            em[i] = 1'b0; er[i] = 1'b0; ef[i] = 1'b0; ec[i] = '0;
        end
    endtask

    task automatic rd_chk(input string tag, input int x, input int y);
        rd_x = x[2:0];
        rd_y = y[2:0];
        #1;
        chk($sformatf("%s_cell_%0d_%0d", tag, x, y),
            {26'd0, rd_mine, rd_revealed, rd_flag, rd_count},
            {26'd0, em[ci(x,y)], er[ci(x,y)], ef[ci(x,y)], ec[ci(x,y)]});
    endtask

    task automatic sweep(input string tag);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                rd_chk(tag, x, y);
    endtask

    task automatic issue(input logic [1:0] op, input int x, input int y,
                         output int lat, output logic res, output logic e);
        int n;
        int guard;
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = x[2:0];
        cmd_y     = y[2:0];
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n = 1;
        chk("ready_low_after_accept", {31'd0, cmd_ready}, 32'd0);
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        lat = n;
        res = result;
        e   = err;
    endtask

    initial begin
        int   lat;
        logic r, e;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("in_reset_ready", {31'd0, cmd_ready}, 32'd1);
        chk("in_reset_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_result", {31'd0, result}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_mine_total", {25'd0, mine_total}, 32'd0);
        chk("rst_revealed_total", {25'd0, revealed_total}, 32'd0);
        clr_exp();
        sweep("rst");

        // Interior mine
        issue(2'd1, 3, 3, lat, r, e);
        chk("p33_lat", lat, 10);
        chk("p33_res", {31'd0, r}, 32'd0);
        chk("p33_err", {31'd0, e}, 32'd0);
        em[ci(3,3)] = 1'b1;
        for (int y = 2; y <= 4; y++)
            for (int x = 2; x <= 4; x++)
                if (!(x == 3 && y == 3)) ec[ci(x,y)] = 3'd1;
        sweep("p33");
        chk("p33_mine_total", {25'd0, mine_total}, 32'd1);

        // Corner mine and duplicate
        issue(2'd1, 0, 0, lat, r, e);
        chk("p00_lat", lat, 10);
        chk("p00_res", {31'd0, r}, 32'd0);
        em[ci(0,0)] = 1'b1;
        ec[ci(1,0)] = 3'd1; ec[ci(0,1)] = 3'd1; ec[ci(1,1)] = 3'd1;
`ifdef TORUS_WRAP_EN
        ec[ci(7,7)] = 3'd1; ec[ci(7,0)] = 3'd1; ec[ci(0,7)] = 3'd1;
        ec[ci(7,1)] = 3'd1; ec[ci(1,7)] = 3'd1;
`endif
        sweep("p00");
        chk("p00_mine_total", {25'd0, mine_total}, 32'd2);
        issue(2'd1, 0, 0, lat, r, e);
        chk("dup_lat", lat, 2);
        chk("dup_res", {31'd0, r}, 32'd1);
        chk("dup_err", {31'd0, e}, 32'd0);
        sweep("dup");
        chk("dup_mine_total", {25'd0, mine_total}, 32'd2);

        // Clear after activity
        issue(2'd0, 0, 0, lat, r, e);
        chk("clr_lat", lat, 65);
        chk("clr_res", {31'd0, r}, 32'd0);
        clr_exp();
        sweep("clr");
        chk("clr_mine_total", {25'd0, mine_total}, 32'd0);

        // Count saturation: eight mines around (4,4)
        issue(2'd1, 4, 3, lat, r, e);
        chk("sat_first_lat", lat, 10);
        issue(2'd1, 5, 3, lat, r, e);
        issue(2'd1, 5, 4, lat, r, e);
        issue(2'd1, 5, 5, lat, r, e);
        issue(2'd1, 4, 5, lat, r, e);
        issue(2'd1, 3, 5, lat, r, e);
        issue(2'd1, 3, 4, lat, r, e);
        issue(2'd1, 3, 3, lat, r, e);
        chk("sat_last_res", {31'd0, r}, 32'd0);
        em[ci(4,4)] = 1'b0; ec[ci(4,4)] = 3'd7;
        rd_chk("sat", 4, 4);
        em[ci(4,3)] = 1'b1; ec[ci(4,3)] = 3'd4;
        rd_chk("sat", 4, 3);
        em[ci(3,3)] = 1'b1; ec[ci(3,3)] = 3'd2;
        rd_chk("sat", 3, 3);
        chk("sat_mine_total", {25'd0, mine_total}, 32'd8);

        issue(2'd0, 0, 0, lat, r, e);
        chk("clr2_lat", lat, 65);
        clr_exp();
        sweep("clr2");
        chk("clr2_mine_total", {25'd0, mine_total}, 32'd0);

        // Flag blocks reveal
        issue(2'd3, 5, 5, lat, r, e);
        chk("flag_lat", lat, 2);
        chk("flag_res", {31'd0, r}, 32'd0);
        chk("flag_err", {31'd0, e}, 32'd0);
        ef[ci(5,5)] = 1'b1;
        rd_chk("flag_on", 5, 5);
        issue(2'd2, 5, 5, lat, r, e);
        chk("rev_flagged_lat", lat, 2);
        chk("rev_flagged_err", {31'd0, e}, 32'd1);
        chk("rev_flagged_res", {31'd0, r}, 32'd0);
        chk("rev_flagged_total", {25'd0, revealed_total}, 32'd0);
        rd_chk("rev_flagged", 5, 5);
        issue(2'd3, 5, 5, lat, r, e);
        ef[ci(5,5)] = 1'b0;
        rd_chk("flag_off", 5, 5);
        issue(2'd2, 5, 5, lat, r, e);
        chk("rev_err", {31'd0, e}, 32'd0);
        chk("rev_res", {31'd0, r}, 32'd0);
        chk("rev_total", {25'd0, revealed_total}, 32'd1);
        er[ci(5,5)] = 1'b1;
        rd_chk("rev", 5, 5);
        issue(2'd3, 5, 5, lat, r, e);
        rd_chk("flag_on_revealed", 5, 5);

        // Reveal a mine, then reveal it again
        issue(2'd1, 1, 6, lat, r, e);
        em[ci(1,6)] = 1'b1;
        ec[ci(1,5)] = 3'd1; ec[ci(2,5)] = 3'd1; ec[ci(2,6)] = 3'd1; ec[ci(2,7)] = 3'd1;
        ec[ci(1,7)] = 3'd1; ec[ci(0,7)] = 3'd1; ec[ci(0,6)] = 3'd1; ec[ci(0,5)] = 3'd1;
        issue(2'd2, 1, 6, lat, r, e);
        chk("rev_mine_res", {31'd0, r}, 32'd1);
        chk("rev_mine_total", {25'd0, revealed_total}, 32'd2);
        er[ci(1,6)] = 1'b1;
        issue(2'd2, 1, 6, lat, r, e);
        chk("rev_again_res", {31'd0, r}, 32'd1);
        chk("rev_again_total", {25'd0, revealed_total}, 32'd2);
        sweep("flags");

        // Reset during the neighbour phase
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_x = 3'd2; cmd_y = 3'd2;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rd_x = 3'd2; rd_y = 3'd2;
        #1;
        chk("mid_mine_set", {31'd0, rd_mine}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_mine", {31'd0, rd_mine}, 32'd0);
        chk("mid_rst_mine_total", {25'd0, mine_total}, 32'd0);
        chk("mid_rst_revealed_total", {25'd0, revealed_total}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        clr_exp();
        sweep("mid_rst");

        // Opposite corner after reset
        issue(2'd1, 7, 7, lat, r, e);
        chk("p77_lat", lat, 10);
        chk("p77_res", {31'd0, r}, 32'd0);
        em[ci(7,7)] = 1'b1;
        ec[ci(6,6)] = 3'd1; ec[ci(7,6)] = 3'd1; ec[ci(6,7)] = 3'd1;
`ifdef TORUS_WRAP_EN
        ec[ci(0,6)] = 3'd1; ec[ci(0,7)] = 3'd1; ec[ci(0,0)] = 3'd1;
        ec[ci(7,0)] = 3'd1; ec[ci(6,0)] = 3'd1;
`endif
        sweep("p77");
        chk("p77_mine_total", {25'd0, mine_total}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
